// File: rtl/vproc_alu_pipe.sv
// Elastic vector integer ALU slice: packed 8/16/32-bit element ops with byte
// masking, followed by a configurable chain of valid/ready register stages.
module vproc_alu_pipe #(
    parameter int ALU_OP_W    = 64,
    parameter int PIPE_STAGES = 2,
    parameter int CTRL_W      = 64
) (
    input  logic                  clk_i,
    input  logic                  async_rst_i,
    input  logic                  pipe_in_valid_i,
    output logic                  pipe_in_ready_o,
    input  logic [CTRL_W-1:0]     pipe_in_ctrl_i,
    input  logic [3:0]            pipe_in_op_i,
    input  logic [1:0]            pipe_in_eew_i,
    input  logic [ALU_OP_W-1:0]   pipe_in_op1_i,
    input  logic [ALU_OP_W-1:0]   pipe_in_op2_i,
    input  logic [ALU_OP_W/8-1:0] pipe_in_mask_i,
    output logic                  pipe_out_valid_o,
    input  logic                  pipe_out_ready_i,
    output logic [CTRL_W-1:0]     pipe_out_ctrl_o,
    output logic [ALU_OP_W-1:0]   pipe_out_res_alu_o,
    output logic [ALU_OP_W/8-1:0] pipe_out_res_cmp_o,
    output logic [ALU_OP_W/8-1:0] pipe_out_mask_o
);
    localparam int NB = ALU_OP_W / 8;

    // Returns {cmp_bit, result}; operands arrive zero-extended from the element width.
    function automatic logic [32:0] f_elem(input logic [3:0] op, input logic [1:0] ew,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, r;
        logic signed [31:0] sa, sb;
        logic ltu, lts, c;
        case (ew)
            2'd0: begin
                ua = {24'd0, a[7:0]};
                ub = {24'd0, b[7:0]};
                sa = {{24{a[7]}}, a[7:0]};
                sb = {{24{b[7]}}, b[7:0]};
            end
            2'd1: begin
                ua = {16'd0, a[15:0]};
                ub = {16'd0, b[15:0]};
                sa = {{16{a[15]}}, a[15:0]};
                sb = {{16{b[15]}}, b[15:0]};
            end
            default: begin
                ua = a;
                ub = b;
                sa = a;
                sb = b;
            end
        endcase
        ltu = ub < ua;
        lts = sb < sa;
        r   = '0;
        c   = 1'b0;
        case (op)
            4'd0:    r = ua + ub;
            4'd1:    r = ub - ua;
            4'd2:    r = ua & ub;
            4'd3:    r = ua | ub;
            4'd4:    r = ua ^ ub;
            4'd5:    r = ltu ? ub : ua;
            4'd6:    r = lts ? ub : ua;
            4'd7:    r = ltu ? ua : ub;
            4'd8:    r = lts ? ua : ub;
            4'd9:    c = (ua == ub);
            4'd10:   c = (ua != ub);
            4'd11:   c = ltu;
            4'd12:   c = lts;
            default: ;
        endcase
        return {c, r};
    endfunction

    logic [ALU_OP_W-1:0] w_res8, w_res16, w_res32, w_res;
    logic [NB-1:0]       w_cmp8, w_cmp16, w_cmp32, w_cmp;
    logic [32:0]         w_e;

    always_comb begin
        w_res8  = '0;
        w_res16 = '0;
        w_res32 = '0;
        w_cmp8  = '0;
        w_cmp16 = '0;
        w_cmp32 = '0;
        w_e     = '0;
        for (int k = 0; k < NB; k++) begin
            w_e = f_elem(pipe_in_op_i, 2'd0, {24'd0, pipe_in_op1_i[8*k +: 8]},
                         {24'd0, pipe_in_op2_i[8*k +: 8]});
            if (pipe_in_mask_i[k]) begin
                w_res8[8*k +: 8] = w_e[7:0];
                w_cmp8[k]        = w_e[32];
            end
        end
        for (int k = 0; k < NB / 2; k++) begin
            w_e = f_elem(pipe_in_op_i, 2'd1, {16'd0, pipe_in_op1_i[16*k +: 16]},
                         {16'd0, pipe_in_op2_i[16*k +: 16]});
            if (pipe_in_mask_i[2*k]) begin
                w_res16[16*k +: 16] = w_e[15:0];
                w_cmp16[2*k]        = w_e[32];
            end
        end
        for (int k = 0; k < NB / 4; k++) begin
            w_e = f_elem(pipe_in_op_i, 2'd2, pipe_in_op1_i[32*k +: 32],
                         pipe_in_op2_i[32*k +: 32]);
            if (pipe_in_mask_i[4*k]) begin
                w_res32[32*k +: 32] = w_e[31:0];
                w_cmp32[4*k]        = w_e[32];
            end
        end
        case (pipe_in_eew_i)
            2'd0:    begin w_res = w_res8;  w_cmp = w_cmp8;  end
            2'd1:    begin w_res = w_res16; w_cmp = w_cmp16; end
            default: begin w_res = w_res32; w_cmp = w_cmp32; end
        endcase
    end

    logic [PIPE_STAGES-1:0] r_vld;
    logic [PIPE_STAGES-1:0] w_load;
    logic [PIPE_STAGES-1:0] w_in_vld;
    logic [CTRL_W-1:0]      r_ctrl  [PIPE_STAGES];
    logic [ALU_OP_W-1:0]    r_res   [PIPE_STAGES];
    logic [NB-1:0]          r_cmp   [PIPE_STAGES];
    logic [NB-1:0]          r_msk   [PIPE_STAGES];
    logic [CTRL_W-1:0]      w_in_ctrl [PIPE_STAGES];
    logic [ALU_OP_W-1:0]    w_in_res  [PIPE_STAGES];
    logic [NB-1:0]          w_in_cmp  [PIPE_STAGES];
    logic [NB-1:0]          w_in_msk  [PIPE_STAGES];
    logic                   w_acc;

    // A stage can load if it or any stage after it is empty, or the sink is ready.
    always_comb begin
        w_acc  = pipe_out_ready_i;
        w_load = '0;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
            w_acc     = w_acc | ~r_vld[i];
            w_load[i] = w_acc;
        end
    end

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_in_vld[g]  = pipe_in_valid_i;
            assign w_in_ctrl[g] = pipe_in_ctrl_i;
            assign w_in_res[g]  = w_res;
            assign w_in_cmp[g]  = w_cmp;
            assign w_in_msk[g]  = pipe_in_mask_i;
        end else begin : g_body
            assign w_in_vld[g]  = r_vld[g-1];
            assign w_in_ctrl[g] = r_ctrl[g-1];
            assign w_in_res[g]  = r_res[g-1];
            assign w_in_cmp[g]  = r_cmp[g-1];
            assign w_in_msk[g]  = r_msk[g-1];
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_vld <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_ctrl[i] <= '0;
                r_res[i]  <= '0;
                r_cmp[i]  <= '0;
                r_msk[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= w_in_vld[i];
                    if (w_in_vld[i]) begin
                        r_ctrl[i] <= w_in_ctrl[i];
                        r_res[i]  <= w_in_res[i];
                        r_cmp[i]  <= w_in_cmp[i];
                        r_msk[i]  <= w_in_msk[i];
                    end
                end
            end
        end
    end

    assign pipe_in_ready_o    = w_load[0];
    assign pipe_out_valid_o   = r_vld[PIPE_STAGES-1];
    assign pipe_out_ctrl_o    = r_ctrl[PIPE_STAGES-1];
    assign pipe_out_res_alu_o = r_res[PIPE_STAGES-1];
    assign pipe_out_res_cmp_o = r_cmp[PIPE_STAGES-1];
    assign pipe_out_mask_o    = r_msk[PIPE_STAGES-1];
endmodule
